demux4_rr_dispatcher: RTL

- Controller for the 1-to-4 demultiplexer: captures one word from a single upstream valid/ready source and steers it to one of four downstream lanes.
- Lane choice is either round-robin over the lanes that are ready (mode 0) or directed by a destination field (mode 1).
- Drives the lane select and per-lane valid. Unselected lanes carry zero data, matching the demux's combinational semantics.
- Sits between the input stream and four consumer blocks.

---
 rtl/demux4_rr_dispatcher.sv | 102 ++++++++++
 1 files changed

// File: rtl/demux4_rr_dispatcher.sv
// Single-word dispatcher for a 1-to-4 demux: captures one upstream word and
// steers it to a round-robin or directed lane, holding it until that lane accepts.
module demux4_rr_dispatcher #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [1:0]            in_dst,
  input  logic                  mode,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [4*DATA_W-1:0]   out_data,
  output logic [1:0]            sel,
  output logic                  busy,
  output logic [CNT_W-1:0]      xfer_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        sel_q, sel_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // First ready lane scanning upward from ptr; falls back to ptr when none is ready.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] rdy);
    logic [1:0] lane;
    rr_pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      lane = ptr + 2'(i);
      if (rdy[lane]) rr_pick = lane;
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    mode_d   = mode_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = HOLD;
          data_d  = in_data;
          mode_d  = mode;
          sel_d   = mode ? in_dst : rr_pick(rr_ptr_q, out_ready);
        end
      end
      HOLD: begin
        if (out_ready[sel_q]) begin
          state_d = IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
          // Directed transfers leave the round-robin position untouched.
          if (!mode_q) rr_ptr_d = sel_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= 2'd0;
      sel_q    <= 2'd0;
      mode_q   <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    out_valid = 4'b0000;
    out_data  = '0;
    if (state_q == HOLD) begin
      out_valid[sel_q]                           = 1'b1;
      out_data[int'(sel_q)*DATA_W +: DATA_W]     = data_q;
    end
  end

  assign in_ready = (state_q == IDLE) && !rst;
  assign busy     = (state_q == HOLD);
  assign sel      = sel_q;
  assign xfer_cnt = cnt_q;

endmodule
